// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the two-master single-port SRAM arbiter.
package sram_port_arbiter_pkg;

   localparam int unsigned NUM_MASTERS    = 2;
   localparam int unsigned ADDR_WIDTH_DEF = 27;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned NUM_WMASKS_DEF = 4;
   localparam int unsigned REQ_ADDR_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves only when a grant is issued.
module rr_arbiter2
   import sram_port_arbiter_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic                   en_i,
   output logic [NUM_MASTERS-1:0] gnt_c_o
);

   // ptr_q = 1 means m1 has priority on a tie
   logic ptr_q;

   always_comb begin
      gnt_c_o = '0;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_c_o = ptr_q ? 2'b10 : 2'b01;
         end else begin
            gnt_c_o = req_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= 1'b0;
      end else if (|gnt_c_o) begin
         ptr_q <= ~gnt_c_o[1];
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two request/response masters,
// one transaction in flight at a time, fixed two-cycle read latency.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned NUM_WMASKS = NUM_WMASKS_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic [REQ_ADDR_W-1:0] m0_req_addr,
   input  logic                  m0_req_we,
   input  logic [NUM_WMASKS-1:0] m0_req_wmask,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   output logic                  m0_rsp_valid,
   input  logic                  m0_rsp_ready,
   output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic [REQ_ADDR_W-1:0] m1_req_addr,
   input  logic                  m1_req_we,
   input  logic [NUM_WMASKS-1:0] m1_req_wmask,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   output logic                  m1_rsp_valid,
   input  logic                  m1_rsp_ready,
   output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);

   state_e                 state_q;
   logic                   owner_q;
   logic                   we_q;
   logic [NUM_MASTERS-1:0] rsp_valid_q;
   logic [DATA_WIDTH-1:0]  rdata_q;

   logic [NUM_MASTERS-1:0] req_valid_c;
   logic [NUM_MASTERS-1:0] gnt_c;
   logic                   arb_en_c;
   logic                   accept_c;
   logic                   sel_c;
   logic                   sel_we_c;
   logic [REQ_ADDR_W-1:0]  sel_addr_c;
   logic [NUM_WMASKS-1:0]  sel_wmask_c;
   logic [DATA_WIDTH-1:0]  sel_wdata_c;
   logic                   rsp_ready_c;
   logic                   unused_addr_c;

   assign req_valid_c = {m1_req_valid, m0_req_valid};
   assign arb_en_c    = (state_q == ST_IDLE) && !reset;

   rr_arbiter2 u_arb (
      .clk_i   (clock),
      .reset_i (reset),
      .req_i   (req_valid_c),
      .en_i    (arb_en_c),
      .gnt_c_o (gnt_c)
   );

   assign accept_c    = |gnt_c;
   assign sel_c       = gnt_c[1];
   assign sel_we_c    = sel_c ? m1_req_we    : m0_req_we;
   assign sel_addr_c  = sel_c ? m1_req_addr  : m0_req_addr;
   assign sel_wmask_c = sel_c ? m1_req_wmask : m0_req_wmask;
   assign sel_wdata_c = sel_c ? m1_req_wdata : m0_req_wdata;
   assign rsp_ready_c = owner_q ? m1_rsp_ready : m0_rsp_ready;

   // Byte offset and bits above the SRAM word range are intentionally dropped
   assign unused_addr_c = ^sel_addr_c;

   assign m0_req_ready = gnt_c[0];
   assign m1_req_ready = gnt_c[1];

   // SRAM port is driven only in the accept cycle, idle values otherwise
   always_comb begin
      csb0   = 1'b1;
      web0   = 1'b1;
      wmask0 = '0;
      addr0  = '0;
      din0   = '0;
      if (accept_c) begin
         csb0  = 1'b0;
         web0  = ~sel_we_c;
         addr0 = sel_addr_c[ADDR_WIDTH+1:2];
         if (sel_we_c) begin
            wmask0 = sel_wmask_c;
            din0   = sel_wdata_c;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  state_q <= ST_WAIT;
                  owner_q <= sel_c;
                  we_q    <= sel_we_c;
               end
            end
            ST_WAIT: begin
               rdata_q     <= we_q ? '0 : dout0;
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready_c) begin
                  rsp_valid_q <= '0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m0_rsp_valid = rsp_valid_q[0];
   assign m1_rsp_valid = rsp_valid_q[1];
   assign m0_rsp_rdata = rdata_q;
   assign m1_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal values.
module tb_sram_port_arbiter;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   logic          clock;
   logic          reset;
   logic          m0_req_valid, m1_req_valid;
   logic          m0_req_ready, m1_req_ready;
   logic [31:0]   m0_req_addr,  m1_req_addr;
   logic          m0_req_we,    m1_req_we;
   logic [MW-1:0] m0_req_wmask, m1_req_wmask;
   logic [DW-1:0] m0_req_wdata, m1_req_wdata;
   logic          m0_rsp_valid, m1_rsp_valid;
   logic          m0_rsp_ready, m1_rsp_ready;
   logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
   logic          csb0, web0;
   logic [MW-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sram_port_arbiter dut (
      .clock(clock), .reset(reset),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_req_we(m0_req_we), .m0_req_wmask(m0_req_wmask), .m0_req_wdata(m0_req_wdata),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
      .m1_req_we(m1_req_we), .m1_req_wmask(m1_req_wmask), .m1_req_wdata(m1_req_wdata),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // SRAM device: dout valid the cycle after a read is sampled
   logic [31:0] sram_mem [0:63];
   always @(posedge clock) begin
      if (!csb0) begin
         if (!web0) begin
            for (int b = 0; b < 4; b++)
               if (wmask0[b]) sram_mem[addr0[5:0]][8*b +: 8] = din0[8*b +: 8];
         end else begin
            dout0 <= sram_mem[addr0[5:0]];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: when free, pick a winner by the round-robin rule; the
   // winner's response appears two cycles later and persists until consumed.
   logic [31:0] ref_mem [0:63];
   int          since     = -1;
   int          last      = 1;
   int          owner     = 0;
   logic [31:0] exp_data  = '0;
   logic        prev_rst  = 1'b0;

   always @(negedge clock) begin
      logic [1:0]    e_rdy, e_rv;
      logic          e_csb, e_web, g_we;
      logic [MW-1:0] e_wm, g_wm;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din, g_wd;
      logic [31:0]   g_addr;
      int            g;
      e_rdy = '0; e_rv = '0; e_csb = 1'b1; e_web = 1'b1;
      e_wm = '0; e_addr = '0; e_din = '0; g = -1;
      if (reset) begin
         if (prev_rst) begin
            chk("rst_rdata0", 64'(m0_rsp_rdata), 64'd0);
            chk("rst_rdata1", 64'(m1_rsp_rdata), 64'd0);
         end
         since = -1;
         last  = 1;
      end else if (since < 0) begin
         if (m0_req_valid && m1_req_valid) g = (last == 0) ? 1 : 0;
         else if (m0_req_valid) g = 0;
         else if (m1_req_valid) g = 1;
         if (g >= 0) begin
            g_we   = (g == 1) ? m1_req_we    : m0_req_we;
            g_addr = (g == 1) ? m1_req_addr  : m0_req_addr;
            g_wm   = (g == 1) ? m1_req_wmask : m0_req_wmask;
            g_wd   = (g == 1) ? m1_req_wdata : m0_req_wdata;
            e_rdy[g] = 1'b1;
            e_csb    = 1'b0;
            e_web    = !g_we;
            e_addr   = AW'(g_addr >> 2);
            if (g_we) begin
               e_wm  = g_wm;
               e_din = g_wd;
               for (int b = 0; b < 4; b++)
                  if (g_wm[b]) ref_mem[g_addr[7:2]][8*b +: 8] = g_wd[8*b +: 8];
               exp_data = '0;
            end else begin
               exp_data = ref_mem[g_addr[7:2]];
            end
            owner = g;
            last  = g;
            since = 1;
         end
      end else if (since == 1) begin
         since = 2;
      end else begin
         e_rv[owner] = 1'b1;
         chk("m_rdata", 64'((owner == 1) ? m1_rsp_rdata : m0_rsp_rdata), 64'(exp_data));
         if ((owner == 1) ? m1_rsp_ready : m0_rsp_ready) since = -1;
      end
      prev_rst = reset;
      chk("m_rdy0",  64'(m0_req_ready), 64'(e_rdy[0]));
      chk("m_rdy1",  64'(m1_req_ready), 64'(e_rdy[1]));
      chk("m_rv0",   64'(m0_rsp_valid), 64'(e_rv[0]));
      chk("m_rv1",   64'(m1_rsp_valid), 64'(e_rv[1]));
      chk("m_csb0",  64'(csb0),   64'(e_csb));
      chk("m_web0",  64'(web0),   64'(e_web));
      chk("m_wmask", 64'(wmask0), 64'(e_wm));
      chk("m_addr0", 64'(addr0),  64'(e_addr));
      chk("m_din0",  64'(din0),   64'(e_din));
   end

   task automatic set_req(input int m, input logic v, input logic we, input logic [31:0] a,
                          input logic [3:0] wm, input logic [31:0] wd);
      if (m == 0) begin
         m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wmask = wm; m0_req_wdata = wd;
      end else begin
         m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wmask = wm; m1_req_wdata = wd;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One complete transaction with literal expectations on drive, latency and data
   task automatic do_req(input int m, input logic we, input logic [31:0] a, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [26:0] exp_a, input logic [31:0] exp_rd,
                         input string nm);
      int  t0;
      bit  got;
      set_req(m, 1'b1, we, a, wm, wd);
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if ((m == 0) ? m0_req_ready : m1_req_ready) begin got = 1; break; end
      end
      chk({nm, "_acc"}, 64'(got), 64'd1);
      chk({nm, "_csb"}, 64'(csb0), 64'd0);
      chk({nm, "_web"}, 64'(web0), 64'(!we));
      chk({nm, "_addr"}, 64'(addr0), 64'(exp_a));
      if (we) chk({nm, "_wmask"}, 64'(wmask0), 64'(wm));
      t0 = cyc;
      tick();
      set_req(m, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if ((m == 0) ? m0_rsp_valid : m1_rsp_valid) begin got = 1; break; end
      end
      chk({nm, "_rsp"}, 64'(got), 64'd1);
      chk({nm, "_lat"}, 64'(cyc - t0), 64'd2);
      chk({nm, "_rdata"}, 64'((m == 0) ? m0_rsp_rdata : m1_rsp_rdata), 64'(exp_rd));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g, prev_c, hs, t0;
      bit got;
      logic [31:0] held;
      for (int i = 0; i < 64; i++) begin
         sram_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
      sram_mem[2] = 32'hAABB_CCDD; ref_mem[2] = 32'hAABB_CCDD;
      sram_mem[8] = 32'h1234_5678; ref_mem[8] = 32'h1234_5678;
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // single read, masked write, read-back (upper address bits ignored)
      do_req(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 27'd4, 32'hDEAD_BEEF, "rd");
      do_req(1, 1'b1, 32'h0000_0008, 4'b0101, 32'h1122_3344, 27'd2, 32'h0, "wr");
      do_req(0, 1'b0, 32'hE000_000B, 4'h0, 32'h0, 27'd2, 32'hAA22_CC44, "rb");

      // contention from reset: alternate m0,m1 with three-cycle spacing
      reset = 1'b1;
      set_req(0, 1'b1, 1'b0, 32'h10, 4'd0, 32'd0);
      set_req(1, 1'b1, 1'b0, 32'h20, 4'd0, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      n = 0; prev_c = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clock);
         if (m0_req_ready || m1_req_ready) begin
            g = m1_req_ready ? 1 : 0;
            chk($sformatf("rr_grant%0d", n), 64'(g), 64'(n % 2));
            if (n > 0) chk($sformatf("rr_gap%0d", n), 64'(cyc - prev_c), 64'd3);
            prev_c = cyc;
            n++;
         end
      end
      chk("rr_count", 64'(n), 64'd4);
      tick();
      set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      repeat (5) tick();

      // backpressure on m0 while m1 waits
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m0_rsp_ready = 1'b0;
      set_req(0, 1'b1, 1'b0, 32'h10, 4'd0, 32'd0);
      set_req(1, 1'b1, 1'b0, 32'h20, 4'd0, 32'd0);
      @(negedge clock);
      chk("bp_acc0", 64'(m0_req_ready), 64'd1);
      tick();
      set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      got = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (m0_rsp_valid) begin got = 1; break; end
      end
      chk("bp_rsp", 64'(got), 64'd1);
      held = m0_rsp_rdata;
      chk("bp_data", 64'(held), 64'h0000_0000_DEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("bp_rv", 64'(m0_rsp_valid), 64'd1);
         chk("bp_hold", 64'(m0_rsp_rdata), 64'(held));
         chk("bp_m1rdy", 64'(m1_req_ready), 64'd0);
         if (k < 4) tick();
      end
      tick();
      m0_rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp_hs_rv", 64'(m0_rsp_valid), 64'd1);
      hs = cyc;
      tick();
      @(negedge clock);
      chk("bp_m1_acc", 64'(m1_req_ready), 64'd1);
      chk("bp_m1_when", 64'(cyc - hs), 64'd1);
      tick();
      set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      repeat (4) tick();

      // reset while waiting for SRAM data discards the response
      set_req(0, 1'b1, 1'b0, 32'h10, 4'd0, 32'd0);
      @(negedge clock);
      chk("rw_acc", 64'(m0_req_ready), 64'd1);
      t0 = cyc;
      tick();
      set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("rw_in_csb", 64'(csb0), 64'd1);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("rw_no_rv", 64'(m0_rsp_valid), 64'd0);
         chk("rw_csb", 64'(csb0), 64'd1);
         tick();
      end
      chk("rw_elapsed", 64'(cyc - t0 > 2), 64'd1);
      do_req(0, 1'b0, 32'h20, 4'h0, 32'h0, 27'd8, 32'h1234_5678, "ar");

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
